// File: rtl/cv32e40p_ldm_event_gen.sv
// Event generator for the LDM basic-block length detector: turns retire/trap
// activity into registered init/decrement strobes and owns the alarm handshake.
module cv32e40p_ldm_event_gen #(
  parameter int unsigned MAX_BB_LEN    = 16,
  parameter bit          HALT_ON_ALARM = 1'b1,
  localparam int unsigned CW           = $clog2(MAX_BB_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic          retire_i,
  input  logic          retire_cf_i,
  input  logic          trap_entry_i,
  input  logic          alarm_i,
  input  logic          alarm_ack_i,
  input  logic          clear_i,
  output logic          init_o,
  output logic          decrement_o,
  output logic          alarm_req_o,
  output logic          alarm_pending_o,
  output logic          alarm_cause_o,
  output logic [CW-1:0] bb_len_o,
  output logic          halt_req_o
);

  localparam logic [2:0] DISABLED = 3'd0;
  localparam logic [2:0] ARM      = 3'd1;
  localparam logic [2:0] ACTIVE   = 3'd2;
  localparam logic [2:0] ALARM    = 3'd3;
  localparam logic [2:0] LOCKED   = 3'd4;

  localparam logic [CW-1:0] BB_MAX = CW'(MAX_BB_LEN);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] bb_cnt_q, bb_cnt_d;
  logic          init_d, decrement_d, alarm_req_d, halt_req_d;
  logic          alarm_pending_d, alarm_cause_d;
  logic [CW-1:0] bb_len_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= DISABLED;
      bb_cnt_q        <= '0;
      init_o          <= 1'b1;
      decrement_o     <= 1'b1;
      alarm_req_o     <= 1'b0;
      halt_req_o      <= 1'b0;
      alarm_pending_o <= 1'b0;
      alarm_cause_o   <= 1'b0;
      bb_len_o        <= '0;
    end else begin
      state_q         <= state_d;
      bb_cnt_q        <= bb_cnt_d;
      init_o          <= init_d;
      decrement_o     <= decrement_d;
      alarm_req_o     <= alarm_req_d;
      halt_req_o      <= halt_req_d;
      alarm_pending_o <= alarm_pending_d;
      alarm_cause_o   <= alarm_cause_d;
      bb_len_o        <= bb_len_d;
    end
  end

  // Next state and next output values; detector is masked (init=dec=1) by default
  always_comb begin
    state_d         = state_q;
    bb_cnt_d        = bb_cnt_q;
    init_d          = 1'b1;
    decrement_d     = 1'b1;
    alarm_req_d     = 1'b0;
    halt_req_d      = 1'b0;
    alarm_pending_d = alarm_pending_o;
    alarm_cause_d   = alarm_cause_o;
    bb_len_d        = bb_len_o;

    case (state_q)
      DISABLED: begin
        if (clear_i) begin
          alarm_pending_d = 1'b0;
          alarm_cause_d   = 1'b0;
          bb_len_d        = '0;
        end
        if (enable_i) state_d = ARM;
      end

      ARM: begin
        bb_cnt_d = '0;
        state_d  = enable_i ? ACTIVE : DISABLED;
      end

      ACTIVE: begin
        if (alarm_i) begin
          // Alarm wins over disable and over a same-cycle retire
          state_d         = ALARM;
          alarm_pending_d = 1'b1;
          alarm_cause_d   = (bb_cnt_q == BB_MAX) ? 1'b0 : 1'b1;
          bb_len_d        = bb_cnt_q;
          alarm_req_d     = 1'b1;
          halt_req_d      = HALT_ON_ALARM;
        end else if (!enable_i) begin
          state_d = DISABLED;
        end else if (trap_entry_i || (retire_i && retire_cf_i)) begin
          bb_cnt_d = '0;
        end else if (retire_i) begin
          init_d = 1'b0;
          if (bb_cnt_q != BB_MAX) bb_cnt_d = bb_cnt_q + CW'(1);
        end else begin
          init_d      = 1'b0;
          decrement_d = 1'b0;
        end
      end

      ALARM: begin
        if (alarm_ack_i) begin
          state_d = LOCKED;
        end else begin
          alarm_req_d = 1'b1;
          halt_req_d  = HALT_ON_ALARM;
        end
      end

      LOCKED: begin
        if (clear_i) begin
          alarm_pending_d = 1'b0;
          alarm_cause_d   = 1'b0;
          bb_len_d        = '0;
          state_d         = enable_i ? ARM : DISABLED;
        end else if (!enable_i) begin
          state_d = DISABLED;
        end
      end

      default: state_d = DISABLED;
    endcase
  end

endmodule

// File: tb/tb_cv32e40p_ldm_event_gen.sv
// Directed bench for cv32e40p_ldm_event_gen with MAX_BB_LEN=4; the detector's
// alarm level is driven directly by the stimulus.
module tb_cv32e40p_ldm_event_gen;

  localparam int unsigned MAXL = 4;
  localparam int unsigned LW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_i, retire_i, retire_cf_i, trap_entry_i;
  logic          alarm_i, alarm_ack_i, clear_i;
  logic          init_o, decrement_o, alarm_req_o, alarm_pending_o;
  logic          alarm_cause_o, halt_req_o;
  logic [LW-1:0] bb_len_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_ldm_event_gen #(.MAX_BB_LEN(MAXL), .HALT_ON_ALARM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .retire_i(retire_i),
    .retire_cf_i(retire_cf_i), .trap_entry_i(trap_entry_i), .alarm_i(alarm_i),
    .alarm_ack_i(alarm_ack_i), .clear_i(clear_i), .init_o(init_o),
    .decrement_o(decrement_o), .alarm_req_o(alarm_req_o),
    .alarm_pending_o(alarm_pending_o), .alarm_cause_o(alarm_cause_o),
    .bb_len_o(bb_len_o), .halt_req_o(halt_req_o)
  );

  always #5 clk = ~clk;

  // Output bundle: {init, dec, req, pending, cause, halt, bb_len[2:0]}
  function automatic logic [8:0] outs();
    return {init_o, decrement_o, alarm_req_o, alarm_pending_o, alarm_cause_o,
            halt_req_o, bb_len_o};
  endfunction

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge
  task automatic step(input logic en, input logic ret, input logic cf,
                      input logic trap, input logic alm, input logic ack,
                      input logic clr);
    enable_i = en; retire_i = ret; retire_cf_i = cf; trap_entry_i = trap;
    alarm_i = alm; alarm_ack_i = ack; clear_i = clr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL reset_values got %b exp %b", outs(), exp); end
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL disabled_idle got %b exp %b", outs(), exp); end
  endtask

  task automatic test_watchdog();
    logic [8:0] exp;
    step(1, 0, 0, 0, 0, 0, 0);                  // DISABLED -> ARM
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL wd_arm got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 0, 0);                  // ARM -> ACTIVE
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL wd_after_arm got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 1, 0);                  // idle, stray ack ignored
    exp = 9'b000000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL wd_idle got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 1, 0, 0);                  // watchdog alarm, bb_cnt=0
    exp = 9'b111111_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL wd_alarm got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 1, 0);                  // ack -> LOCKED
    exp = 9'b110110_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL wd_locked got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 0, 1);                  // clear -> ARM
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL wd_clear got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 0, 0);                  // -> ACTIVE
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL wd_rearm got %b exp %b", outs(), exp); end
  endtask

  task automatic test_block_len();
    logic [8:0] exp;
    exp = 9'b010000_000;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (outs() !== exp) begin errors++; $display("FAIL bl_retire%0d got %b exp %b", i, outs(), exp); end
    end
    step(0, 1, 0, 0, 1, 0, 0);                  // alarm beats retire and disable
    exp = 9'b111101_100;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL bl_alarm got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 1, 0);
    exp = 9'b110100_100;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL bl_locked got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL bl_rearm got %b exp %b", outs(), exp); end
  endtask

  task automatic test_cf_and_trap();
    logic [8:0] exp;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    exp = 9'b010000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL cf_pre got %b exp %b", outs(), exp); end
    step(1, 1, 1, 0, 0, 0, 0);                  // CF retire
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL cf_init got %b exp %b", outs(), exp); end
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    exp = 9'b010000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL cf_post got %b exp %b", outs(), exp); end
    step(1, 1, 0, 1, 0, 0, 0);                  // trap with non-CF retire
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL trap_init got %b exp %b", outs(), exp); end
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);                  // bb_cnt=3 after trap clear
    exp = 9'b111111_011;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL trap_cnt got %b exp %b", outs(), exp); end
  endtask

  task automatic test_ack_hold();
    logic [8:0] exp;
    exp = 9'b111111_011;
    for (int i = 0; i < 4; i++) begin
      step((i != 1), 0, 0, 0, 0, 0, (i == 2)); // disable/clear ignored in ALARM
      checks++;
      if (outs() !== exp) begin errors++; $display("FAIL hold%0d got %b exp %b", i, outs(), exp); end
    end
    step(1, 0, 0, 0, 0, 1, 0);
    exp = 9'b110110_011;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL hold_ack got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 0, 1);
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL hold_clear got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    exp = 9'b000000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL hold_active got %b exp %b", outs(), exp); end
  endtask

  task automatic test_reset_mid_alarm();
    logic [8:0] exp;
    step(1, 0, 0, 0, 1, 0, 0);
    exp = 9'b111111_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL rm_alarm got %b exp %b", outs(), exp); end
    #2 rst_n = 1'b0;
    #1;
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL rm_async got %b exp %b", outs(), exp); end
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);                  // DISABLED -> ARM
    step(1, 0, 0, 0, 0, 0, 0);                  // ARM -> ACTIVE
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL rm_arm got %b exp %b", outs(), exp); end
    step(1, 0, 0, 0, 0, 0, 0);
    exp = 9'b000000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL rm_active got %b exp %b", outs(), exp); end
  endtask

  task automatic test_locked_disable();
    logic [8:0] exp;
    step(1, 0, 0, 0, 1, 1, 0);                  // ack already high on entry
    step(1, 0, 0, 0, 0, 1, 0);
    exp = 9'b110110_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL ld_locked got %b exp %b", outs(), exp); end
    step(0, 0, 0, 0, 0, 0, 0);                  // -> DISABLED, still sticky
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL ld_sticky got %b exp %b", outs(), exp); end
    step(0, 0, 0, 0, 0, 0, 1);                  // clear in DISABLED
    exp = 9'b110000_000;
    checks++;
    if (outs() !== exp) begin errors++; $display("FAIL ld_clear got %b exp %b", outs(), exp); end
  endtask

  initial begin
    rst_n = 1'b0;
    enable_i = 0; retire_i = 0; retire_cf_i = 0; trap_entry_i = 0;
    alarm_i = 0; alarm_ack_i = 0; clear_i = 0;
    test_reset();
    test_watchdog();
    test_block_len();
    test_cf_and_trap();
    test_ack_hold();
    test_reset_mid_alarm();
    test_locked_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
